// File: rtl/tmr_vote_out_buffer.sv
// Output buffer behind the TMR voter: show-ahead FIFO of voted words plus
// error statistics and a consecutive-error monitor with a sticky alarm.
module tmr_vote_out_buffer #(
  parameter int DATA_LEN  = 27,
  parameter int DEPTH     = 4,
  parameter int ERR_LIMIT = 3,
  parameter int CNT_W     = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [DATA_LEN-1:0] in_data,
  input  logic                in_tmr_error,
  output logic                in_ready,
  output logic                out_valid,
  output logic [DATA_LEN-1:0] out_data,
  output logic                out_err,
  input  logic                out_ready,
  input  logic                clr_alarm,
  output logic [CNT_W-1:0]    err_count,
  output logic                alarm,
  output logic [1:0]          mon_state,
  output logic                first_err_valid,
  output logic [DATA_LEN-1:0] first_err_data
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;
  localparam logic [OW-1:0]    DEPTH_C = OW'(DEPTH);
  localparam logic [7:0]       LIMIT_C = 8'(ERR_LIMIT);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_NORMAL   = 2'b00,
    ST_DEGRADED = 2'b01,
    ST_ALARM    = 2'b10
  } mon_state_e;

  logic [DATA_LEN:0]   mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [OW-1:0]       count_q, count_d;
  logic                push_s, pop_s;
  logic [DATA_LEN:0]   head_s;

  logic [CNT_W-1:0]    err_cnt_q, err_cnt_d, err_base_s;
  logic [7:0]          consec_q, consec_d, consec_base_s, consec_inc_s;
  logic                fev_q, fev_d, fev_base_s;
  logic [DATA_LEN-1:0] fed_q, fed_d, fed_base_s;
  mon_state_e          state_q, state_d, state_base_s;

  assign in_ready  = (count_q != DEPTH_C);
  assign out_valid = (count_q != {OW{1'b0}});
  assign push_s    = in_valid & in_ready;
  assign pop_s     = out_valid & out_ready;
  assign head_s    = mem_q[rd_ptr_q];

  // Head entry is shown directly from storage; zero while empty so reset is clean.
  always_comb begin
    out_data = {DATA_LEN{1'b0}};
    out_err  = 1'b0;
    if (out_valid) begin
      out_data = head_s[DATA_LEN-1:0];
      out_err  = head_s[DATA_LEN];
    end else begin
      out_data = {DATA_LEN{1'b0}};
      out_err  = 1'b0;
    end
  end

  // FIFO storage write port (contents are never reset).
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= {in_tmr_error, in_data};
    end
  end

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_s);
    rd_ptr_d = rd_ptr_q + AW'(pop_s);
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + {{(OW-1){1'b0}}, 1'b1};
      2'b01:   count_d = count_q - {{(OW-1){1'b0}}, 1'b1};
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {OW{1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // A clear is applied first, then any word accepted in the same cycle is counted on top.
  always_comb begin
    err_base_s    = clr_alarm ? {CNT_W{1'b0}}    : err_cnt_q;
    consec_base_s = clr_alarm ? 8'd0             : consec_q;
    fev_base_s    = clr_alarm ? 1'b0             : fev_q;
    fed_base_s    = clr_alarm ? {DATA_LEN{1'b0}} : fed_q;
    state_base_s  = clr_alarm ? ST_NORMAL        : state_q;
    consec_inc_s  = (consec_base_s == LIMIT_C) ? LIMIT_C : consec_base_s + 8'd1;
  end

  // Statistics and monitor next-state.
  always_comb begin
    err_cnt_d = err_base_s;
    consec_d  = consec_base_s;
    fev_d     = fev_base_s;
    fed_d     = fed_base_s;
    state_d   = state_base_s;
    if (push_s && in_tmr_error) begin
      err_cnt_d = (err_base_s == CNT_MAX) ? err_base_s : err_base_s + {{(CNT_W-1){1'b0}}, 1'b1};
      consec_d  = consec_inc_s;
      if (!fev_base_s) begin
        fev_d = 1'b1;
        fed_d = in_data;
      end else begin
        fev_d = fev_base_s;
        fed_d = fed_base_s;
      end
      case (state_base_s)
        ST_ALARM: state_d = ST_ALARM;
        default:  state_d = (consec_inc_s == LIMIT_C) ? ST_ALARM : ST_DEGRADED;
      endcase
    end else if (push_s) begin
      consec_d = 8'd0;
      case (state_base_s)
        ST_DEGRADED: state_d = ST_NORMAL;
        ST_ALARM:    state_d = ST_ALARM;
        default:     state_d = ST_NORMAL;
      endcase
    end else begin
      consec_d = consec_base_s;
      state_d  = state_base_s;
    end
  end

  // Statistics and monitor registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_q <= {CNT_W{1'b0}};
      consec_q  <= 8'd0;
      fev_q     <= 1'b0;
      fed_q     <= {DATA_LEN{1'b0}};
      state_q   <= ST_NORMAL;
    end else begin
      err_cnt_q <= err_cnt_d;
      consec_q  <= consec_d;
      fev_q     <= fev_d;
      fed_q     <= fed_d;
      state_q   <= state_d;
    end
  end

  assign err_count       = err_cnt_q;
  assign mon_state       = state_q;
  assign alarm           = (state_q == ST_ALARM);
  assign first_err_valid = fev_q;
  assign first_err_data  = fed_q;

endmodule

// File: tb/tb_tmr_vote_out_buffer.sv
// Self-checking bench: queue scoreboard for the FIFO path, a small statistics
// model, and a vector table with hand-written expectations for the monitor.
module tb_tmr_vote_out_buffer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [26:0] in_data;
  logic        in_tmr_error;
  logic        in_ready;
  logic        out_valid;
  logic [26:0] out_data;
  logic        out_err;
  logic        out_ready;
  logic        clr_alarm;
  logic [7:0]  err_count;
  logic        alarm;
  logic [1:0]  mon_state;
  logic        first_err_valid;
  logic [26:0] first_err_data;

  tmr_vote_out_buffer dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_tmr_error(in_tmr_error),
    .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_err(out_err),
    .out_ready(out_ready), .clr_alarm(clr_alarm),
    .err_count(err_count), .alarm(alarm), .mon_state(mon_state),
    .first_err_valid(first_err_valid), .first_err_data(first_err_data)
  );

  always #5 clk = ~clk;

  int nchecks = 0;
  int nerrors = 0;

  logic [27:0] mq[$];
  logic [26:0] seen[$];
  int          m_cnt, m_consec;
  bit          m_fev;
  logic [26:0] m_fed;
  logic [1:0]  m_state;
  bit          last_push;

  typedef struct {
    bit          v;
    logic [26:0] d;
    bit          e;
    bit          clr;
    int          cnt;
    logic [1:0]  st;
    bit          fev;
    logic [26:0] fed;
  } vec_t;
  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerrors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_cnt = 0; m_consec = 0; m_fev = 0; m_fed = '0; m_state = 2'b00;
  endtask

  task automatic set_in(input bit v, input logic [26:0] d, input bit e, input bit rdy, input bit clr);
    in_valid = v; in_data = d; in_tmr_error = e; out_ready = rdy; clr_alarm = clr;
  endtask

  // One clock: check handshake/head before the edge, advance the model, check stats after.
  task automatic step();
    bit          m_push, m_pop;
    logic [27:0] w;
    m_push = in_valid && (mq.size() < 4);
    m_pop  = out_ready && (mq.size() != 0);
    chk("in_ready", in_ready, (mq.size() < 4));
    chk("out_valid", out_valid, (mq.size() != 0));
    if (mq.size() != 0) begin
      w = mq[0];
      chk("out_data", out_data, w[26:0]);
      chk("out_err", out_err, w[27]);
    end else begin
      chk("out_data_empty", out_data, 0);
    end
    @(posedge clk);
    #1;
    if (m_pop) begin
      w = mq.pop_front();
      seen.push_back(w[26:0]);
    end
    if (m_push) mq.push_back({in_tmr_error, in_data});
    if (clr_alarm) begin
      m_cnt = 0; m_consec = 0; m_fev = 0; m_fed = '0; m_state = 2'b00;
    end
    if (m_push && in_tmr_error) begin
      if (m_cnt < 255) m_cnt++;
      if (m_consec < 3) m_consec++;
      if (!m_fev) begin m_fev = 1; m_fed = in_data; end
      if (m_state != 2'b10) m_state = (m_consec == 3) ? 2'b10 : 2'b01;
    end else if (m_push) begin
      m_consec = 0;
      if (m_state == 2'b01) m_state = 2'b00;
    end
    last_push = m_push;
    chk("err_count", err_count, m_cnt);
    chk("mon_state", mon_state, m_state);
    chk("alarm", alarm, (m_state == 2'b10));
    chk("first_err_valid", first_err_valid, m_fev);
    chk("first_err_data", first_err_data, m_fed);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"}, out_data, 0);
    chk({tag, "_out_err"}, out_err, 0);
    chk({tag, "_err_count"}, err_count, 0);
    chk({tag, "_alarm"}, alarm, 0);
    chk({tag, "_mon_state"}, mon_state, 0);
    chk({tag, "_fev"}, first_err_valid, 0);
    chk({tag, "_fed"}, first_err_data, 0);
  endtask

  initial begin
    int max_occ;
    bool_accept: begin end
    vecs[0]  = '{1, 27'h5A5A5A5, 1, 0, 1, 2'b01, 1, 27'h5A5A5A5};
    vecs[1]  = '{1, 27'h1111111, 1, 0, 2, 2'b01, 1, 27'h5A5A5A5};
    vecs[2]  = '{1, 27'h0000AAA, 0, 0, 2, 2'b00, 1, 27'h5A5A5A5};
    vecs[3]  = '{1, 27'h0000101, 1, 0, 3, 2'b01, 1, 27'h5A5A5A5};
    vecs[4]  = '{1, 27'h0000102, 1, 0, 4, 2'b01, 1, 27'h5A5A5A5};
    vecs[5]  = '{1, 27'h0000103, 1, 0, 5, 2'b10, 1, 27'h5A5A5A5};
    vecs[6]  = '{1, 27'h0000104, 0, 0, 5, 2'b10, 1, 27'h5A5A5A5};
    vecs[7]  = '{0, 27'h0000000, 0, 1, 0, 2'b00, 0, 27'h0000000};
    vecs[8]  = '{1, 27'h0000201, 1, 0, 1, 2'b01, 1, 27'h0000201};
    vecs[9]  = '{1, 27'h0000202, 1, 0, 2, 2'b01, 1, 27'h0000201};
    vecs[10] = '{1, 27'h0000203, 1, 0, 3, 2'b10, 1, 27'h0000201};
    vecs[11] = '{1, 27'h0000204, 1, 1, 1, 2'b01, 1, 27'h0000204};
    vecs[12] = '{0, 27'h0000000, 0, 0, 1, 2'b01, 1, 27'h0000204};
    vecs[13] = '{0, 27'h7FFFFFF, 1, 0, 1, 2'b01, 1, 27'h0000204};

    // Power-on reset
    reset = 1'b1;
    set_in(0, '0, 0, 0, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    reset = 1'b0;

    // Fill to full with out_ready low; 5th word (erroneous) must be held, not counted
    for (int i = 1; i <= 4; i++) begin
      set_in(1, 27'(i), 0, 0, 0);
      step();
    end
    chk("full_in_ready", in_ready, 0);
    set_in(1, 27'h0000005, 1, 0, 0);
    step();
    step();
    chk("held_not_counted", err_count, 0);
    set_in(1, 27'h0000005, 1, 1, 0);
    last_push = 0;
    for (int i = 0; i < 10 && !last_push; i++) step();
    chk("word5_accepted", last_push, 1);
    set_in(0, '0, 0, 1, 0);
    repeat (6) step();
    chk("drain_count", seen.size(), 5);
    for (int i = 0; i < 5 && i < seen.size(); i++) chk("drain_order", seen[i], i + 1);
    chk("word5_counted", err_count, 1);

    // Clear statistics, then stream 16 words with out_ready high
    set_in(0, '0, 0, 1, 1);
    step();
    seen.delete();
    max_occ = 0;
    for (int i = 0; i < 16; i++) begin
      set_in(1, 27'h100 + 27'(i), 0, 1, 0);
      step();
      if (i == 0) chk("first_out_valid_latency", out_valid, 1);
      if (mq.size() > max_occ) max_occ = mq.size();
    end
    set_in(0, '0, 0, 1, 0);
    repeat (3) step();
    chk("stream_max_occ", max_occ, 1);
    chk("stream_count", seen.size(), 16);
    for (int i = 0; i < 16 && i < seen.size(); i++) chk("stream_order", seen[i], 27'h100 + 27'(i));

    // Error statistics and monitor vectors
    for (int i = 0; i < 14; i++) begin
      set_in(vecs[i].v, vecs[i].d, vecs[i].e, 1, vecs[i].clr);
      step();
      chk("vec_err_count", err_count, vecs[i].cnt);
      chk("vec_mon_state", mon_state, vecs[i].st);
      chk("vec_alarm", alarm, (vecs[i].st == 2'b10));
      chk("vec_fev", first_err_valid, vecs[i].fev);
      chk("vec_fed", first_err_data, vecs[i].fed);
    end

    // Saturation of the total error counter
    for (int i = 0; i < 260; i++) begin
      set_in(1, 27'(i), 1, 1, 0);
      step();
    end
    chk("sat_err_count", err_count, 8'hFF);
    chk("sat_alarm", alarm, 1);
    set_in(0, '0, 0, 1, 1);
    step();
    set_in(0, '0, 0, 1, 0);
    repeat (2) step();

    // Async reset mid-stream with 3 buffered words and alarm raised
    for (int i = 0; i < 3; i++) begin
      set_in(1, 27'h300 + 27'(i), 1, 0, 0);
      step();
    end
    chk("pre_reset_alarm", alarm, 1);
    chk("pre_reset_out_valid", out_valid, 1);
    set_in(0, '0, 0, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk_reset_outputs("async");
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    seen.delete();
    set_in(1, 27'h0ABCDEF, 0, 1, 0);
    step();
    set_in(0, '0, 0, 1, 0);
    step();
    step();
    chk("post_reset_count", seen.size(), 1);
    if (seen.size() > 0) chk("post_reset_word", seen[0], 27'h0ABCDEF);

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/tmr_vote_out_buffer.md
Name: tmr_vote_out_buffer

Overview:
- Downstream consumer of the TMR voter stage. Captures each voted 27-bit word and its TMR_error flag into a small show-ahead FIFO with valid/ready handshaking toward the next stage.
- Tracks error statistics: saturating total error count, consecutive-error counter, first-error snapshot.
- Runs a monitor state machine that raises a sticky alarm after ERR_LIMIT consecutive erroneous votes.

Parameters:
DATA_LEN, 27, width of voted data word
DEPTH, 4, FIFO entries; power of two, minimum 2
ERR_LIMIT, 3, consecutive erroneous words that trigger ALARM; range 1..255
CNT_W, 8, width of total error counter

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
in_valid  input  1  voted word present on in_data/in_tmr_error
in_data  input  DATA_LEN  voted data word from voter
in_tmr_error  input  1  voter TMR_error for this word
in_ready  output  1  buffer can accept; equals !full
out_valid  output  1  FIFO non-empty
out_data  output  DATA_LEN  head entry data
out_err  output  1  head entry error flag
out_ready  input  1  downstream consumes head when out_valid high
clr_alarm  input  1  synchronous clear of alarm and statistics
err_count  output  CNT_W  total accepted erroneous words, saturating
alarm  output  1  sticky alarm
mon_state  output  2  00 NORMAL, 01 DEGRADED, 10 ALARM
first_err_valid  output  1  first_err_data holds a captured word
first_err_data  output  DATA_LEN  data of first erroneous word since reset/clear

Behaviour:
- Reset (async): FIFO empty, pointers 0. in_ready=1, out_valid=0, out_data=0, out_err=0, err_count=0, alarm=0, mon_state=NORMAL, first_err_valid=0, first_err_data=0, internal consecutive counter=0. FIFO storage need not be cleared. Reset mid-operation discards all buffered words immediately.
- Push = in_valid & in_ready. Pop = out_valid & out_ready. Both are evaluated at the rising edge.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Full/empty are distinguished by an occupancy counter (0..DEPTH).
- Show-ahead: out_data/out_err reflect the head entry combinationally from storage. An empty-to-non-empty transition gives out_valid=1 in the cycle after the push (latency 1). There is no bypass.
- Full: in_ready=0. An in_valid word is not accepted and the upstream holds it; a pop while full does not enable a push in the same cycle.
- Empty with a simultaneous push: push only; out_valid=1 next cycle.
- Non-empty, non-full with push and pop in the same cycle: occupancy is unchanged and both pointers advance.
- out_data and out_err are held stable while out_valid=1 and out_ready=0.
- Statistics update only on accepted words (push). Words rejected while full are not counted.
  - Erroneous push: err_count increments and saturates at 2^CNT_W-1. The consecutive counter increments and saturates at ERR_LIMIT.
  - Clean push: consecutive counter is cleared to 0.
  - First erroneous push while first_err_valid=0: latch in_data into first_err_data and set first_err_valid. Later errors do not overwrite.
- Monitor FSM (registered), transitions evaluated on a push:
  - NORMAL -> DEGRADED on an erroneous push when the new consecutive count < ERR_LIMIT.
  - NORMAL or DEGRADED -> ALARM when the new consecutive count == ERR_LIMIT. With ERR_LIMIT=1, the first error goes straight to ALARM.
  - DEGRADED -> NORMAL on a clean push.
  - ALARM: stays until clr_alarm; pushes still update counters.
  - alarm = (mon_state==ALARM).
- clr_alarm (synchronous):
  - Clears err_count, the consecutive counter, first_err_valid and first_err_data; mon_state -> NORMAL. FIFO contents are unaffected.
  - If a push occurs in the same cycle, the clear is applied first and the pushed word is then counted. An erroneous push yields err_count=1, consec=1, first_err captured, and state DEGRADED (or ALARM if ERR_LIMIT=1).

Test Plan:
- Reset, then push 4 clean words 0x0000001..0x0000004 with out_ready=0 -> in_ready drops after the 4th accept. A 5th word 0x0000005 is held and not counted. With out_ready=1, words emerge in order 1,2,3,4, then 5 once it is accepted.
- Continuous push/pop streaming 16 words with out_ready=1 -> occupancy stays ≤1, no loss or reorder, and first out_valid occurs one cycle after the first push.
- Errors: push err words 0x5A5A5A5, 0x1111111 then a clean word -> err_count=2, first_err_data=0x5A5A5A5, mon_state goes NORMAL->DEGRADED->DEGRADED->NORMAL, alarm=0.
- Three consecutive erroneous pushes (ERR_LIMIT=3) -> alarm=1 on the cycle after the 3rd accept. A following clean push keeps alarm=1. Asserting clr_alarm gives alarm=0, err_count=0, first_err_valid=0.
- clr_alarm coincident with an erroneous push while in ALARM -> next cycle: err_count=1, first_err_valid=1 holding the new word, mon_state=DEGRADED.
- Async reset asserted mid-stream with 3 words buffered and alarm=1 -> all outputs return to reset values immediately, without waiting for a clock edge. After release, the first new word is output correctly.
